tgl2pls_rx: RTL and testbench
=============================

// Module: tgl2pls_rx
// PURPOSE
//  Destination-domain receiver for toggle-encoded CDC events from the pulse-to-toggle sender.
//  - Synchronises the asynchronous toggle into clk.
//  - Edge-detects it into a one-cycle pulse.
//  - Queues events in a saturating pending counter with a valid/ready output handshake.
//  - Counts events lost to back-pressure.
//  - Sits directly downstream of the source-domain toggle register.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flops on tgl_in; legal range >=2
//  PEND_W       4  pending counter width; max queued events = 2**PEND_W-1
//  CNT_W        8  overflow counter width; saturates at 2**CNT_W-1
// PORTS
//  clk        in   1        destination clock
//  rst_n      in   1        reset, asynchronous, active-low
//  tgl_in     in   1        toggle from source domain, asynchronous to clk; each level change = one event
//  pulse      out  1        one-cycle strobe per detected toggle edge (unqueued)
//  evt_valid  out  1        at least one event pending
//  evt_ready  in   1        consumer accepts one event when evt_valid && evt_ready
//  pend_cnt   out  PEND_W   number of events pending
//  ovf        out  1        sticky: an event was dropped
//  ovf_cnt    out  CNT_W    dropped-event count, saturating
//  ovf_clr    in   1        synchronous clear of ovf and ovf_cnt
// BEHAVIOUR
//  Reset (async assert, sync-to-clk release handled upstream):
//  - sync chain = 0, edge reference flop = 0.
//  - pulse=0, pend_cnt=0, evt_valid=0, ovf=0, ovf_cnt=0.
//  - Chain resets to 0 to match the sender's reset toggle level, so no spurious event at reset release.
//  Synchroniser: plain flop chain s[0..SYNC_STAGES-1]; no logic between stages.
//  Edge reference: ref <= s[SYNC_STAGES-1] every cycle.
//  pulse = s[SYNC_STAGES-1] ^ ref (combinational from flops).
//  - High exactly 1 cycle per tgl_in change.
//  - First edge k samples the new level into s[0]; pulse is high in the cycle after edge k+SYNC_STAGES-1.
//  - tgl_in changes must be >= SYNC_STAGES+1 clk cycles apart, otherwise events are lost (sender-side rule).
//  Pending counter, updated on the clock edge that ends a pulse cycle. Let acc = evt_valid && evt_ready.
//  - pulse && !acc: increment. At max, stays at max and overflow fires.
//  - !pulse && acc: decrement.
//  - pulse && acc: unchanged, including at max. No overflow.
//  - Neither: hold.
//  evt_valid = (pend_cnt != 0), taken from the register.
//  - First evt_valid follows pulse by 1 cycle: SYNC_STAGES+1 edges after tgl_in is sampled.
//  - evt_ready while !evt_valid is ignored; the counter never underflows.
//  Overflow event: sets ovf=1 and increments ovf_cnt, saturating (no wrap).
//  ovf_clr:
//  - Clears ovf and ovf_cnt to 0 next edge.
//  - If an overflow event occurs in the same cycle, the overflow wins: ovf=1, ovf_cnt=1.
//  No FSM beyond the counters. All outputs are registered or XOR of two flops; no combinational input->output path.
//  Reset mid-operation: all state returns to reset values immediately; pending events are discarded.
//  - Sender and receiver must be reset together so toggle parity realigns.
// TESTING
//  1. Reset, tgl_in=0 held 20 cycles -> pulse, evt_valid, ovf never assert; pend_cnt=0.
//  2. SYNC_STAGES=2, one 0->1 toggle, ready=1:
//     - pulse high exactly 1 cycle, 2 edges after sampling; evt_valid high exactly 1 cycle, 1 cycle after pulse.
//  3. PEND_W=2, ready=0, 5 toggles spaced 4 cycles:
//     - pend_cnt=3, ovf=1, ovf_cnt=2.
//     - Then ready=1 -> exactly 3 accepts, pend_cnt=0.
//  4. pend_cnt=3 (max), pulse coincides with accept -> pend_cnt stays 3, ovf_cnt unchanged.
//  5. ovf_cnt=5, ovf_clr same cycle as an overflow -> ovf=1, ovf_cnt=1.
//     - Next ovf_clr alone -> ovf=0, ovf_cnt=0.
//  6. rst_n low mid-stream (pend_cnt=2, toggle in flight) -> all outputs 0 asynchronously.
//     - After release with tgl_in=0, no pulse.
//  Also: CNT_W=2 saturation -> ovf_cnt sticks at 3. Random toggle/ready soak vs scoreboard with an accept+pending+dropped == toggles check.

Source files
------------

// File: rtl/tgl2pls_rx.sv
// Destination-side receiver for toggle-encoded CDC events.
// Synchronises the toggle, turns each level change into a pulse, and queues events behind a valid/ready handshake.
module tgl2pls_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tgl_in,
  output logic              pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf,
  output logic [CNT_W-1:0]  ovf_cnt,
  input  logic              ovf_clr
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ref_q, ref_d;
  logic [PEND_W-1:0]      pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       ovf_cnt_q, ovf_cnt_d;
  logic                   accept;
  logic                   ovf_evt;

  assign pulse     = sync_q[SYNC_STAGES-1] ^ ref_q;
  assign evt_valid = (pend_q != '0);
  assign accept    = evt_valid && evt_ready;
  assign pend_cnt  = pend_q;
  assign ovf       = ovf_q;
  assign ovf_cnt   = ovf_cnt_q;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], tgl_in};
    ref_d     = sync_q[SYNC_STAGES-1];
    pend_d    = pend_q;
    ovf_evt   = 1'b0;
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;

    // A pulse that coincides with an accept leaves the count alone, even when full.
    if (pulse && !accept) begin
      if (pend_q == PEND_MAX) ovf_evt = 1'b1;
      else                    pend_d  = pend_q + PEND_W'(1);
    end else if (!pulse && accept) begin
      pend_d = pend_q - PEND_W'(1);
    end

    // An overflow in the same cycle as a clear restarts the count at one.
    if (ovf_evt) begin
      ovf_d = 1'b1;
      if (ovf_clr)                     ovf_cnt_d = CNT_W'(1);
      else if (ovf_cnt_q != CNT_MAX)   ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end else if (ovf_clr) begin
      ovf_d     = 1'b0;
      ovf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      ref_q     <= 1'b0;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      sync_q    <= sync_d;
      ref_q     <= ref_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

endmodule

// File: tb/tb_tgl2pls_rx.sv
// Scoreboard bench for tgl2pls_rx: toggles push their expected pulse cycle,
// a monitor pops them and tracks pending/overflow state with plain arithmetic.
module tb_tgl2pls_rx;
  localparam int SS   = 2;
  localparam int PW   = 2;
  localparam int CW   = 3;
  localparam int PMAX = 3;
  localparam int CMAX = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tgl_in = 1'b0;
  logic          evt_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          pulse, evt_valid, ovf;
  logic [PW-1:0] pend_cnt;
  logic [CW-1:0] ovf_cnt;

  always #5 clk = ~clk;

  tgl2pls_rx #(.SYNC_STAGES(SS), .PEND_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .tgl_in(tgl_in), .pulse(pulse),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .pend_cnt(pend_cnt),
    .ovf(ovf), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_q[$];
  int toggles = 0, accepts = 0, drops = 0;
  int m_pend = 0, m_ovf_cnt = 0;
  bit m_ovf = 1'b0, m_pulse = 1'b0, v_s = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  // Monitor: advance the reference model on each edge, then compare 1 time unit later.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_pend = 0; m_ovf = 0; m_ovf_cnt = 0; m_pulse = 0; v_s = 0;
      accepts = 0; drops = 0;
    end else begin
      bit acc_m, oe;
      acc_m = (m_pend != 0) && evt_ready;
      if (v_s && evt_ready) accepts++;
      oe = 1'b0;
      if (m_pulse && !acc_m) begin
        if (m_pend == PMAX) oe = 1'b1;
        else m_pend++;
      end else if (!m_pulse && acc_m) begin
        m_pend--;
      end
      if (oe) begin
        drops++;
        m_ovf = 1'b1;
        m_ovf_cnt = ovf_clr ? 1 : ((m_ovf_cnt < CMAX) ? m_ovf_cnt + 1 : CMAX);
      end else if (ovf_clr) begin
        m_ovf = 1'b0;
        m_ovf_cnt = 0;
      end
      m_pulse = (exp_q.size() > 0) && (exp_q[0] == cyc);
      if (m_pulse) void'(exp_q.pop_front());
      #1;
      if (rst_n) begin
        chk("pulse", pulse, m_pulse);
        chk("evt_valid", evt_valid, m_pend != 0);
        chk("pend_cnt", pend_cnt, m_pend);
        chk("ovf", ovf, m_ovf);
        chk("ovf_cnt", ovf_cnt, m_ovf_cnt);
        v_s = evt_valid;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a falling edge: the next rising edge samples the new level.
  task automatic toggle();
    tgl_in = ~tgl_in;
    exp_q.push_back(cyc + SS);
    toggles++;
  endtask

  initial begin
    int gap;
    int a0;
    int rate;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;

    tick(20);
    chk("idle_pend", pend_cnt, 0);
    chk("idle_valid", evt_valid, 0);

    evt_ready = 1'b1;
    toggle();
    tick(6);
    evt_ready = 1'b0;
    chk("single_drained", pend_cnt, 0);

    for (int i = 0; i < 5; i++) begin toggle(); tick(4); end
    tick(2);
    chk("fill_pend", pend_cnt, 3);
    chk("fill_ovf", ovf, 1);
    chk("fill_ovf_cnt", ovf_cnt, 2);
    a0 = accepts;
    evt_ready = 1'b1;
    tick(8);
    evt_ready = 1'b0;
    chk("drain_accepts", accepts - a0, 3);
    chk("drain_pend", pend_cnt, 0);

    for (int i = 0; i < 3; i++) begin toggle(); tick(4); end
    chk("refill_pend", pend_cnt, 3);
    toggle();
    tick(2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    tick(3);
    chk("coinc_pend", pend_cnt, 3);
    chk("coinc_ovf_cnt", ovf_cnt, 2);

    for (int i = 0; i < 3; i++) begin toggle(); tick(4); end
    chk("ovf_cnt_5", ovf_cnt, 5);
    toggle();
    tick(2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(3);
    chk("clr_race_ovf", ovf, 1);
    chk("clr_race_cnt", ovf_cnt, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    chk("clr_ovf", ovf, 0);
    chk("clr_cnt", ovf_cnt, 0);

    for (int i = 0; i < 9; i++) begin toggle(); tick(4); end
    chk("sat_cnt", ovf_cnt, 7);
    evt_ready = 1'b1;
    ovf_clr = 1'b1;
    tick(6);
    ovf_clr = 1'b0;
    evt_ready = 1'b0;
    chk("clean_pend", pend_cnt, 0);

    toggle(); tick(4);
    toggle(); tick(4);
    chk("pre_rst_pend", pend_cnt, 2);
    toggle();
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pulse", pulse, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    exp_q.delete();
    toggles = 0;
    @(negedge clk);
    tgl_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    chk("post_rst_pend", pend_cnt, 0);

    gap = 0;
    rate = 50;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if (i % 200 == 0) rate = $urandom_range(5, 95);
      evt_ready = ($urandom_range(0, 99) < rate);
      ovf_clr = ($urandom_range(0, 31) == 0);
      if (gap == 0) begin
        toggle();
        gap = SS + $urandom_range(0, 5);
      end else begin
        gap--;
      end
    end
    ovf_clr = 1'b0;
    evt_ready = 1'b1;
    tick(10);
    evt_ready = 1'b0;
    tick(1);
    chk("soak_drained", pend_cnt, 0);
    chk("conservation", accepts + pend_cnt + drops, toggles);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
